// File: rtl/data_ram_ws.sv
// rtl/data_ram_ws.sv - Wait-state 32-bit data RAM with byte enables and out-of-range flag
//
// Purpose: single-port word RAM (2^ADDR_WORDS_LOG2 x 32) answering one request
// at a time after WAIT_CYCLES wait states, with a one-cycle ack pulse.
//
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset
//   req_i    - access request, held by requester until ack_o
//   we_i     - 1 = write, 0 = read
//   addr_i   - byte address, word index = addr_i[ADDR_WORDS_LOG2+1:2]
//   sel_i    - byte enables for writes
//   wdata_i  - write data
//   rdata_o  - read data, holds until the next in-range read completes
//   ack_o    - one-cycle completion pulse
//   err_o    - out-of-range flag, only ever high together with ack_o
//   busy_o   - access in progress
module data_ram_ws #(
    parameter int ADDR_WORDS_LOG2 = 10,
    parameter int WAIT_CYCLES     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        ack_o,
    output logic        err_o,
    output logic        busy_o
);

    localparam int DEPTH = 1 << ADDR_WORDS_LOG2;
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } state_t;

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;

    logic        cap_we;
    logic [31:2] cap_addr;
    logic [3:0]  cap_sel;
    logic [31:0] cap_wdata;
    logic        err_r;
    logic [31:0] rdata_r;

    logic [31:0] mem [0:DEPTH-1];

    // Operands used at the commit edge. With zero wait states the commit edge
    // is the accept edge itself, so the live inputs are used from IDLE.
    logic        use_in;
    logic        op_we;
    logic [31:2] op_addr;
    logic [3:0]  op_sel;
    logic [31:0] op_wdata;
    logic        op_err;
    logic [ADDR_WORDS_LOG2-1:0] op_idx;
    logic        enter_ack;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (req_i) begin
                    if (WAIT_CYCLES == 0) begin
                        state_next = ACK;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_next = ACK;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    always_comb begin
        use_in    = (state == IDLE);
        op_we     = use_in ? we_i          : cap_we;
        op_addr   = use_in ? addr_i[31:2]  : cap_addr;
        op_sel    = use_in ? sel_i         : cap_sel;
        op_wdata  = use_in ? wdata_i       : cap_wdata;
        op_err    = |op_addr[31:ADDR_WORDS_LOG2+2];
        op_idx    = op_addr[ADDR_WORDS_LOG2+1:2];
        enter_ack = (state_next == ACK) && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_sel   <= 4'd0;
            cap_wdata <= 32'd0;
            err_r     <= 1'b0;
            rdata_r   <= 32'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (state == IDLE && req_i) begin
                cap_we    <= we_i;
                cap_addr  <= addr_i[31:2];
                cap_sel   <= sel_i;
                cap_wdata <= wdata_i;
            end
            if (enter_ack) begin
                err_r <= op_err;
                if (!op_we && !op_err) begin
                    rdata_r <= mem[op_idx];
                end
            end
        end
    end

    // Array is deliberately not reset; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (enter_ack && op_we && !op_err) begin
            for (int b = 0; b < 4; b++) begin
                if (op_sel[b]) begin
                    mem[op_idx][8*b +: 8] <= op_wdata[8*b +: 8];
                end
            end
        end
    end

    assign ack_o   = (state == ACK);
    assign err_o   = (state == ACK) && err_r;
    assign busy_o  = (state != IDLE);
    assign rdata_o = rdata_r;

endmodule

// File: tb/tb_data_ram_ws.sv
// tb/tb_data_ram_ws.sv - Self-checking bench for data_ram_ws
module tb_data_ram_ws;

    logic        clk;
    logic        rst;

    logic        req0, we0;
    logic [31:0] addr0, wdata0, rdata0;
    logic [3:0]  sel0;
    logic        ack0, err0, busy0;

    logic        req1, we1;
    logic [31:0] addr1, wdata1, rdata1;
    logic [3:0]  sel1;
    logic        ack1, err1, busy1;

    int n_checks = 0;
    int n_fail   = 0;

    data_ram_ws #(.ADDR_WORDS_LOG2(10), .WAIT_CYCLES(2)) u_ws2 (
        .clk(clk), .rst(rst), .req_i(req0), .we_i(we0), .addr_i(addr0),
        .sel_i(sel0), .wdata_i(wdata0), .rdata_o(rdata0), .ack_o(ack0),
        .err_o(err0), .busy_o(busy0)
    );

    data_ram_ws #(.ADDR_WORDS_LOG2(10), .WAIT_CYCLES(0)) u_ws0 (
        .clk(clk), .rst(rst), .req_i(req1), .we_i(we1), .addr_i(addr1),
        .sel_i(sel1), .wdata_i(wdata1), .rdata_o(rdata1), .ack_o(ack1),
        .err_o(err1), .busy_o(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // One access on the WAIT_CYCLES=2 instance; inputs are scrambled right
    // after the accept edge to show only captured values matter.
    task automatic access(input string name, input logic we, input logic [31:0] addr,
                          input logic [3:0] sel, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err);
        int cyc;
        bit got;
        req0 = 1'b1; we0 = we; addr0 = addr; sel0 = sel; wdata0 = wdata;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 20) begin
            step();
            cyc++;
            if (cyc == 1) begin
                we0 = ~we; addr0 = 32'h0000_0040; sel0 = 4'hF; wdata0 = 32'h5A5A_5A5A;
            end
            if (ack0) begin
                got = 1'b1;
            end else begin
                check({name, " err_without_ack"}, {31'd0, err0}, 32'd0);
            end
        end
        req0 = 1'b0;
        check({name, " latency"}, cyc, 3);
        check({name, " err"}, {31'd0, err0}, {31'd0, exp_err});
        check({name, " rdata"}, rdata0, exp_rdata);
        step();
        check({name, " idle_after_ack"}, {30'd0, busy0, ack0}, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_0010, 4'hF, 32'h1234_5678, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         32'h1234_5678, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0010, 4'h2, 32'hAABB_CCDD, 32'h1234_5678, 1'b0};
        vecs[3]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         32'h1234_CC78, 1'b0};
        vecs[4]  = '{1'b1, 32'h0000_0000, 4'hF, 32'hCAFE_F00D, 32'h1234_CC78, 1'b0};
        vecs[5]  = '{1'b1, 32'h0001_0000, 4'hF, 32'hDEAD_BEEF, 32'h1234_CC78, 1'b1};
        vecs[6]  = '{1'b0, 32'h0000_0000, 4'hF, 32'h0,         32'hCAFE_F00D, 1'b0};
        vecs[7]  = '{1'b0, 32'h0001_0000, 4'hF, 32'h0,         32'hCAFE_F00D, 1'b1};
        vecs[8]  = '{1'b1, 32'h0000_0000, 4'h0, 32'h1111_1111, 32'hCAFE_F00D, 1'b0};
        vecs[9]  = '{1'b0, 32'h0000_0000, 4'hF, 32'h0,         32'hCAFE_F00D, 1'b0};
        vecs[10] = '{1'b0, 32'h0000_0013, 4'h0, 32'h0,         32'h1234_CC78, 1'b0};
        vecs[11] = '{1'b1, 32'h0000_0FFC, 4'hF, 32'h0BAD_BEEF, 32'h1234_CC78, 1'b0};
        vecs[12] = '{1'b0, 32'h0000_1000, 4'hF, 32'h0,         32'h1234_CC78, 1'b1};

        rst = 1'b1;
        req0 = 1'b0; we0 = 1'b0; addr0 = 32'd0; sel0 = 4'd0; wdata0 = 32'd0;
        req1 = 1'b0; we1 = 1'b0; addr1 = 32'd0; sel1 = 4'd0; wdata1 = 32'd0;
        step();
        step();
        check("reset ack",   {31'd0, ack0},  32'd0);
        check("reset err",   {31'd0, err0},  32'd0);
        check("reset busy",  {31'd0, busy0}, 32'd0);
        check("reset rdata", rdata0,         32'd0);
        check("reset ws0 busy_ack", {30'd0, busy1, ack1}, 32'd0);
        check("reset ws0 rdata", rdata1, 32'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 13; i++) begin
            access($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].sel,
                   vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err);
        end
        access("read_last_word", 1'b0, 32'h0000_0FFC, 4'hF, 32'h0, 32'h0BAD_BEEF, 1'b0);

        // Reset during WAIT discards the pending write.
        access("prewrite_0x20", 1'b1, 32'h0000_0020, 4'hF, 32'h0, 32'h0BAD_BEEF, 1'b0);
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h0000_0020; sel0 = 4'hF; wdata0 = 32'hFFFF_FFFF;
        step();
        check("abort busy_in_wait", {31'd0, busy0}, 32'd1);
        rst = 1'b1;
        req0 = 1'b0;
        step();
        rst = 1'b0;
        check("abort busy_after_rst", {31'd0, busy0}, 32'd0);
        check("abort rdata_cleared", rdata0, 32'd0);
        begin
            int acks = 0;
            for (int i = 0; i < 5; i++) begin
                step();
                if (ack0) acks++;
            end
            check("abort no_ack", acks, 0);
        end
        access("read_0x20_after_abort", 1'b0, 32'h0000_0020, 4'hF, 32'h0, 32'h0000_0000, 1'b0);

        // Zero wait states, request held high: ack/busy alternate 1,0.
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h0000_0004; sel1 = 4'hF; wdata1 = 32'h0000_0001;
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("ws0 cyc%0d ack", k),  {31'd0, ack1},  {31'd0, 1'(k % 2)});
            check($sformatf("ws0 cyc%0d busy", k), {31'd0, busy1}, {31'd0, 1'(k % 2)});
            check($sformatf("ws0 cyc%0d err", k),  {31'd0, err1},  32'd0);
            wdata1 = wdata1 + 32'd1;
        end
        req1 = 1'b0;
        step();
        step();
        // Four accepts wrote 1,3,5,7; the last one committed 7.
        req1 = 1'b1; we1 = 1'b0;
        step();
        req1 = 1'b0;
        check("ws0 read ack",   {31'd0, ack1}, 32'd1);
        check("ws0 read rdata", rdata1, 32'h0000_0007);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
